// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one SLICE-bit carry-lookahead slice per stage, carry rippled
// stage to stage through registers, valid/ready handshake with full-rate stall propagation.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int STAGES = WIDTH / SLICE;

  // Returns {carry out of slice MSB, carry into slice MSB, slice sum}.
  function automatic logic [SLICE+1:0] cla_slice(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             term;
    logic             pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & ci);
    end
    return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
  endfunction

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] cy_in;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [SLICE+1:0]  slc;
  logic              ld_run;
  logic              of_q;
  logic              of_d;

  always_comb begin
    // A stage loads when it is empty or everything downstream of it moves.
    ld_run = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld_run = ld_run | ~vld_q[k];
      ld[k]  = ld_run;
    end

    vld_d[0] = in_valid;
    a_d[0]   = a;
    b_d[0]   = sub ? ~b : b;
    cy_in[0] = sub ? 1'b1 : cin;
    s_d[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      cy_in[k] = c_q[k-1];
      s_d[k]   = s_q[k-1];
    end

    slc = '0;
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      slc                       = cla_slice(a_d[k][k*SLICE +: SLICE], b_d[k][k*SLICE +: SLICE], cy_in[k]);
      s_d[k][k*SLICE +: SLICE]  = slc[SLICE-1:0];
      c_d[k]                    = slc[SLICE+1];
    end
    // slc now holds the MSB slice, so its two top carries give signed overflow.
    of_d = slc[SLICE+1] ^ slc[SLICE];
  end

  // Stage boundary: valid bits and the result path, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      of_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld_q[k] <= vld_d[k];
          if (vld_d[k]) begin
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (ld[STAGES-1] && vld_d[STAGES-1]) begin
        of_q <= of_d;
      end
    end
  end

  // Stage boundary: operand skew registers, data only.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (ld[k] && vld_d[k]) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign of        = of_q;

endmodule
